mod15_seq_ctrl: RTL and testbench

Command sequencer and 2-way arbiter in front of one mod-15 up/down counter (ports clk, rst, mode, load, data, data_out).
Two requesters issue commands over valid/ready: READ, LOAD, COUNT_UP n, COUNT_DOWN n.
The block sequences the counter's load/mode pins to carry out each command. The counter has no enable, so the block holds it between commands by reloading its own value. One response pulse is returned per command.

---
 rtl/mod15_seq_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/mod15_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mod15_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod15_seq_pkg.sv
// Shared types and constants for the mod-15 counter command sequencer.
package mod15_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  // Highest value the counter reaches counting up before wrapping to 0.
  localparam int CNT_WRAP = 14;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses a tie on the next contest.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_grant;

  always_comb begin
    grant_id = 1'b0;
    if (valid == 2'b11) grant_id = ~last_grant;
    else if (valid[1])  grant_id = 1'b1;
    grant = 2'b00;
    if (enable && (|valid)) grant[grant_id] = 1'b1;
  end

  // A grant is only issued against a valid request, so any grant is an accept.
  always_ff @(posedge clk) begin
    if (rst)           last_grant <= 1'b1;
    else if (|grant)   last_grant <= grant_id;
  end

endmodule

// File: rtl/mod15_seq_ctrl.sv
// Command sequencer and 2-way arbiter driving a mod-15 up/down counter.
// Optional macro MOD15_SEQ_ABORT_EN adds an abort input for RUN and a resp_aborted flag.
module mod15_seq_ctrl
  import mod15_seq_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [STEP_W-1:0] req0_arg,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [STEP_W-1:0] req1_arg,
  output logic              cnt_load,
  output logic              cnt_mode,
  output logic [CNT_W-1:0]  cnt_data,
  input  logic [CNT_W-1:0]  cnt_value,
`ifdef MOD15_SEQ_ABORT_EN
  input  logic              abort,
  output logic              resp_aborted,
`endif
  output logic              resp_valid,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_value,
  output logic              busy
);

  state_t            state;
  op_t               op_q;
  op_t               op_in;
  logic [STEP_W-1:0] arg_q;
  logic [STEP_W-1:0] arg_in;
  logic [STEP_W-1:0] step_q;
  logic              id_q;
  logic              resp_id_q;
  logic [CNT_W-1:0]  resp_value_q;
  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;
  logic              run_abort;

`ifdef MOD15_SEQ_ABORT_EN
  assign run_abort = abort;
`else
  assign run_abort = 1'b0;
`endif

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    ({req1_valid, req0_valid}),
    .enable   ((state == S_IDLE) && !rst),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign op_in      = op_t'(grant_id ? req1_op : req0_op);
  assign arg_in     = grant_id ? req1_arg : req0_arg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      step_q       <= '0;
      id_q         <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_value_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q   <= op_in;
          arg_q  <= arg_in;
          id_q   <= grant_id;
          step_q <= arg_in;
          case (op_in)
            OP_LOAD:        state <= S_LOAD;
            OP_UP, OP_DOWN: state <= (arg_in != '0) ? S_RUN : S_DONE;
            default:        state <= S_DONE;
          endcase
        end
        S_LOAD: state <= S_DONE;
        // The counter steps on every RUN cycle, including the one that exits.
        S_RUN: begin
          step_q <= step_q - STEP_W'(1);
          if ((step_q == STEP_W'(1)) || run_abort) state <= S_DONE;
        end
        S_DONE: begin
          resp_id_q    <= id_q;
          resp_value_q <= cnt_value;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The counter has no enable: every non-RUN state reloads its own value.
  always_comb begin
    cnt_load = 1'b1;
    cnt_mode = 1'b0;
    cnt_data = cnt_value;
    case (state)
      S_LOAD: cnt_data = arg_q[CNT_W-1:0];
      S_RUN: begin
        cnt_load = 1'b0;
        cnt_mode = (op_q == OP_UP);
      end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE) && !rst;
  assign resp_id    = (state == S_DONE) ? id_q : resp_id_q;
  assign resp_value = (state == S_DONE) ? cnt_value : resp_value_q;

`ifdef MOD15_SEQ_ABORT_EN
  logic aborted_q;

  always_ff @(posedge clk) begin
    if (rst)                             aborted_q <= 1'b0;
    else if ((state == S_IDLE) && accept) aborted_q <= 1'b0;
    else if (state == S_RUN)             aborted_q <= abort;
  end

  assign resp_aborted = resp_valid && aborted_q;
`endif

endmodule

// File: tb/tb_mod15_seq_ctrl.sv
// Self-checking bench for mod15_seq_ctrl with a behavioural mod-15 counter attached.
module tb_mod15_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
  logic [3:0] req0_arg = 4'd0, req1_arg = 4'd0;
  logic       req0_ready, req1_ready;
  logic       cnt_load, cnt_mode;
  logic [3:0] cnt_data, cnt_value;
  logic       resp_valid, resp_id, busy;
  logic [3:0] resp_value;
`ifdef MOD15_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       resp_aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_val  = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  // The attached counter: 14 wraps to 0 going up, 0 gives 15 going down.
  always @(posedge clk) begin
    if (rst)           cnt_value <= 4'd0;
    else if (cnt_load) cnt_value <= cnt_data;
    else if (cnt_mode) cnt_value <= (cnt_value >= 4'd14) ? 4'd0 : cnt_value + 4'd1;
    else               cnt_value <= (cnt_value == 4'd0) ? 4'd15 : cnt_value - 4'd1;
  end

  mod15_seq_ctrl #(.CNT_W(4), .STEP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_arg   (req0_arg),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_arg   (req1_arg),
    .cnt_load   (cnt_load),
    .cnt_mode   (cnt_mode),
    .cnt_data   (cnt_data),
    .cnt_value  (cnt_value),
`ifdef MOD15_SEQ_ABORT_EN
    .abort        (abort),
    .resp_aborted (resp_aborted),
`endif
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_value (resp_value),
    .busy       (busy)
  );

  function automatic int step_up(input int v);
    return (v >= 14) ? 0 : v + 1;
  endfunction

  function automatic int step_dn(input int v);
    return (v == 0) ? 15 : v - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from a single requester, starting in an IDLE cycle.
  task automatic do_cmd(input int id, input logic [1:0] op, input logic [3:0] arg);
    int lat;
    int exp_val;
    exp_val = model_val;
    case (op)
      2'd1: begin exp_val = int'(arg); lat = 2; end
      2'd2: begin for (int i = 0; i < int'(arg); i++) exp_val = step_up(exp_val); lat = int'(arg) + 1; end
      2'd3: begin for (int i = 0; i < int'(arg); i++) exp_val = step_dn(exp_val); lat = int'(arg) + 1; end
      default: lat = 1;
    endcase
    if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_arg = arg; end
    else         begin req1_valid = 1'b1; req1_op = op; req1_arg = arg; end
    #1;
    check("ready_own",   (id == 0) ? req0_ready : req1_ready, 1);
    check("ready_other", (id == 0) ? req1_ready : req0_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check("busy_mid", busy, 1);
      check("resp_early", resp_valid, 0);
      if (op[1]) begin
        check("run_load", cnt_load, 0);
        check("run_mode", cnt_mode, (op == 2'd2));
      end else begin
        check("load_data", cnt_data, arg);
      end
      tick();
    end
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, id);
    check("resp_value", resp_value, exp_val);
`ifdef MOD15_SEQ_ABORT_EN
    check("resp_not_aborted", resp_aborted, 0);
`endif
    model_val  = exp_val;
    model_last = id;
    tick();
    check("resp_single", resp_valid, 0);
    check("busy_idle", busy, 0);
    check("resp_value_hold", resp_value, exp_val);
    check("resp_id_hold", resp_id, id);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req0_op = 2'd0;
    tick();
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_value", resp_value, 0);
    rst = 1'b0;
    req0_valid = 1'b0;
    model_val  = 0;
    model_last = 1;
    tick();
  endtask

  initial begin
    logic [1:0] rop;
    logic [3:0] rarg;
    int         rid;
    int         eg;

    // Reset, LOAD 12, UP 3 through the wrap
    do_reset();
    do_cmd(0, 2'd1, 4'd12);
    do_cmd(0, 2'd2, 4'd3);

    // LOAD 1, DOWN 2 through zero, then the counter must hold
    do_cmd(0, 2'd1, 4'd1);
    do_cmd(1, 2'd3, 4'd2);
    for (int i = 0; i < 5; i++) begin
      check("hold_value", cnt_value, 15);
      check("hold_load", cnt_load, 1);
      tick();
    end

    // Simultaneous requests after reset alternate 0, 1, 0
    do_reset();
    for (int g = 0; g < 3; g++) begin
      eg = 1 - model_last;
      req0_valid = 1'b1; req0_op = 2'd0;
      req1_valid = 1'b1; req1_op = 2'd0;
      #1;
      check("arb_ready0", req0_ready, (eg == 0));
      check("arb_ready1", req1_ready, (eg == 1));
      check("arb_overlap", req0_ready & req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("arb_resp_valid", resp_valid, 1);
      check("arb_resp_id", resp_id, eg);
      check("arb_resp_value", resp_value, model_val);
      model_last = eg;
      tick();
    end

    // Zero-step count and READ
    do_cmd(1, 2'd1, 4'd7);
    do_cmd(0, 2'd2, 4'd0);
    do_cmd(1, 2'd3, 4'd0);
    do_cmd(0, 2'd0, 4'd9);
    check("read_no_change", cnt_value, 7);

    // Reset in the middle of UP 10 drops the command
    req0_valid = 1'b1; req0_op = 2'd2; req0_arg = 4'd10;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_resp", resp_valid, 0);
    check("rst_mid_cnt", cnt_value, 0);
    model_val  = 0;
    model_last = 1;
    for (int i = 0; i < 12; i++) begin
      check("rst_mid_no_resp", resp_valid, 0);
      tick();
    end

`ifdef MOD15_SEQ_ABORT_EN
    // Abort during the second RUN cycle of UP 10 from 0
    req0_valid = 1'b1; req0_op = 2'd2; req0_arg = 4'd10;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_resp_valid", resp_valid, 1);
    check("abort_resp_value", resp_value, 2);
    check("abort_flag", resp_aborted, 1);
    tick();
    check("abort_busy", busy, 0);
    check("abort_flag_clear", resp_aborted, 0);
    model_val  = 2;
    model_last = 0;
`endif

    // Random command stream against the model
    for (int n = 0; n < 40; n++) begin
      rid  = int'($urandom_range(0, 1));
      rop  = 2'($urandom_range(0, 3));
      rarg = (rop == 2'd1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      do_cmd(rid, rop, rarg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
